// File: rtl/vga_bounce_box.sv
// -----------------------------------------------------------------------------
// vga_bounce_box
//
// Animated pattern source for the VGA controller. It draws a solid box on a
// flat background from the controller's pixel coordinates. The box moves once
// per frame and reflects off the edges of the active area.
//
// Ports
//   iVGA_CLK     in   1   pixel clock
//   iRST_N       in   1   synchronous active-low reset
//   iVGA_X       in  10   current pixel X from the VGA controller
//   iVGA_Y       in  10   current pixel Y from the VGA controller
//   iEnable      in   1   1 = animate, 0 = freeze position (drawing continues)
//   oRed         out 10   red pixel value
//   oGreen       out 10   green pixel value
//   oBlue        out 10   blue pixel value
//   oFrame_Tick  out  1   one-cycle pulse after the last active pixel of a frame
//   oBounce_Cnt  out  8   count of frames in which a bounce occurred (wraps)
//
// All outputs are registered. Colour has one cycle of latency from iVGA_X/Y.
// -----------------------------------------------------------------------------
module vga_bounce_box #(
   parameter int          H_ACT   = 640,
   parameter int          V_ACT   = 480,
   parameter int          BOX_W   = 32,
   parameter int          BOX_H   = 32,
   parameter int          STEP    = 2,
   // {R,G,B}, 10 bits per channel
   parameter logic [29:0] BOX_RGB = {10'h3FF, 10'h000, 10'h000},
   parameter logic [29:0] BG_RGB  = {10'h000, 10'h000, 10'h3FF}
) (
   input  logic       iVGA_CLK,
   input  logic       iRST_N,
   input  logic [9:0] iVGA_X,
   input  logic [9:0] iVGA_Y,
   input  logic       iEnable,
   output logic [9:0] oRed,
   output logic [9:0] oGreen,
   output logic [9:0] oBlue,
   output logic       oFrame_Tick,
   output logic [7:0] oBounce_Cnt
);

   localparam logic [10:0] H_ACT11 = 11'(H_ACT);
   localparam logic [10:0] V_ACT11 = 11'(V_ACT);
   localparam logic [10:0] BOX_W11 = 11'(BOX_W);
   localparam logic [10:0] BOX_H11 = 11'(BOX_H);

   // ---------------------------------------------------------------------------
   // Frame tick detection
   // ---------------------------------------------------------------------------
   logic [19:0] prevXyReg;
   logic        lastPix;
   logic        tickNow;
   logic        updateEn;

   assign lastPix  = (iVGA_X == 10'(H_ACT - 1)) && (iVGA_Y == 10'(V_ACT - 1));
   // A controller that parks on the last pixel through blanking must only
   // produce one tick, so the pair has to differ from the previous cycle.
   assign tickNow  = lastPix && ({iVGA_X, iVGA_Y} != prevXyReg);
   // Position moves on the same edge that raises oFrame_Tick.
   assign updateEn = tickNow && iEnable;

   // ---------------------------------------------------------------------------
   // Per-axis position/direction state. Axis 0 is X, axis 1 is Y.
   // ---------------------------------------------------------------------------
   logic [1:0][9:0] axisPos;
   logic [1:0]      axisBounce;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gAxis
         localparam int          ACT    = (gi == 0) ? H_ACT : V_ACT;
         localparam int          DIM    = (gi == 0) ? BOX_W : BOX_H;
         localparam logic [10:0] LIMIT  = 11'(ACT - DIM);
         localparam logic [10:0] STEP11 = 11'(STEP);

         logic [9:0]  posReg;
         logic [9:0]  posNext;
         logic        dirReg;      // 1 = increasing, 0 = decreasing
         logic        dirNext;
         logic        bounceAxis;
         logic [10:0] pos11;

         // 11-bit arithmetic so pos+STEP and pos-STEP never wrap.
         assign pos11 = {1'b0, posReg};

         always_comb begin
            posNext    = posReg;
            dirNext    = dirReg;
            bounceAxis = 1'b0;
            if (dirReg) begin
               if (pos11 + STEP11 >= LIMIT) begin
                  posNext    = 10'(LIMIT);
                  dirNext    = 1'b0;
                  bounceAxis = 1'b1;
               end else begin
                  posNext = 10'(pos11 + STEP11);
               end
            end else begin
               if (pos11 <= STEP11) begin
                  posNext    = 10'd0;
                  dirNext    = 1'b1;
                  bounceAxis = 1'b1;
               end else begin
                  posNext = 10'(pos11 - STEP11);
               end
            end
         end

         always_ff @(posedge iVGA_CLK) begin
            if (!iRST_N) begin
               posReg <= 10'd0;
               dirReg <= 1'b1;
            end else if (updateEn) begin
               posReg <= posNext;
               dirReg <= dirNext;
            end
         end

         assign axisPos[gi]    = posReg;
         assign axisBounce[gi] = bounceAxis;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Pixel path
   // ---------------------------------------------------------------------------
   logic [10:0] x11;
   logic [10:0] y11;
   logic [10:0] boxX11;
   logic [10:0] boxY11;
   logic        activePix;
   logic        insidePix;
   logic [29:0] pixRgb;

   assign x11    = {1'b0, iVGA_X};
   assign y11    = {1'b0, iVGA_Y};
   assign boxX11 = {1'b0, axisPos[0]};
   assign boxY11 = {1'b0, axisPos[1]};

   assign activePix = (x11 < H_ACT11) && (y11 < V_ACT11);
   assign insidePix = (x11 >= boxX11) && (x11 < boxX11 + BOX_W11) &&
                      (y11 >= boxY11) && (y11 < boxY11 + BOX_H11);

   always_comb begin
      pixRgb = 30'd0;
      if (activePix) begin
         pixRgb = insidePix ? BOX_RGB : BG_RGB;
      end
   end

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge iVGA_CLK) begin
      if (!iRST_N) begin
         prevXyReg   <= {10'h3FF, 10'h3FF};
         oFrame_Tick <= 1'b0;
         oBounce_Cnt <= 8'd0;
         oRed        <= 10'd0;
         oGreen      <= 10'd0;
         oBlue       <= 10'd0;
      end else begin
         prevXyReg   <= {iVGA_X, iVGA_Y};
         oFrame_Tick <= tickNow;
         // A corner hit bounces both axes but counts as one frame.
         if (updateEn && (|axisBounce)) begin
            oBounce_Cnt <= oBounce_Cnt + 8'd1;
         end
         {oRed, oGreen, oBlue} <= pixRgb;
      end
   end

endmodule

// File: tb/tb_vga_bounce_box.sv
// -----------------------------------------------------------------------------
// Testbench for vga_bounce_box. Stimulus pushes expected values, tagged with
// the cycle they must appear in, into a queue; a monitor pops and compares.
// dut1 uses default geometry, dut2 a 64x64 area for the corner-hit case.
// -----------------------------------------------------------------------------
module tb_vga_bounce_box;

   localparam logic [29:0] BOX = {10'h3FF, 10'h000, 10'h000};
   localparam logic [29:0] BG  = {10'h000, 10'h000, 10'h3FF};

   localparam int K_RGB  = 0;
   localparam int K_TICK = 1;
   localparam int K_CNT  = 2;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [9:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
   logic       en1 = 1'b0, en2 = 1'b0;

   logic [9:0] r1, g1, b1, r2, g2, b2;
   logic       tick1, tick2;
   logic [7:0] cnt1, cnt2;

   vga_bounce_box dut1 (
      .iVGA_CLK(clk), .iRST_N(rstN), .iVGA_X(x1), .iVGA_Y(y1), .iEnable(en1),
      .oRed(r1), .oGreen(g1), .oBlue(b1), .oFrame_Tick(tick1), .oBounce_Cnt(cnt1)
   );

   vga_bounce_box #(.H_ACT(64), .V_ACT(64)) dut2 (
      .iVGA_CLK(clk), .iRST_N(rstN), .iVGA_X(x2), .iVGA_Y(y2), .iEnable(en2),
      .oRed(r2), .oGreen(g2), .oBlue(b2), .oFrame_Tick(tick2), .oBounce_Cnt(cnt2)
   );

   initial forever #5 clk = ~clk;

   int cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   typedef struct {
      int          cyc;
      int          dut;
      int          kind;
      logic [29:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   bit   stimDone = 1'b0;

   // Inputs change 1 time unit after a rising edge and are captured on the next.
   task automatic drive(input int d, input int x, input int y, input bit en, input bit rst);
      @(posedge clk);
      #1;
      rstN = rst;
      if (d == 1) begin
         x1 = 10'(x); y1 = 10'(y); en1 = en;
      end else begin
         x2 = 10'(x); y2 = 10'(y); en2 = en;
      end
   endtask

   task automatic push(input int d, input int kind, input logic [29:0] e, input string nm, input int ofs);
      exp_t ent;
      ent.cyc  = cycleCnt + ofs;
      ent.dut  = d;
      ent.kind = kind;
      ent.exp  = e;
      ent.name = nm;
      q.push_back(ent);
   endtask

   task automatic pix(input int d, input int x, input int y, input logic [29:0] e, input string nm);
      drive(d, x, y, 1'b1, 1'b1);
      push(d, K_RGB, e, nm, 1);
   endtask

   task automatic cntChk(input int d, input int e, input string nm);
      drive(d, (d == 1) ? 700 : 100, (d == 1) ? 700 : 100, 1'b1, 1'b1);
      push(d, K_CNT, 30'(e), nm, 1);
   endtask

   // One frame: last active pixel for one cycle, then an off-screen pixel.
   task automatic doTick(input int d, input bit en);
      drive(d, (d == 1) ? 639 : 63, (d == 1) ? 479 : 63, en, 1'b1);
      push(d, K_TICK, 30'd1, "tick_pulse", 1);
      drive(d, (d == 1) ? 700 : 100, (d == 1) ? 700 : 100, en, 1'b1);
      push(d, K_TICK, 30'd0, "tick_drop", 1);
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      // Reset held with (5,5), which would be inside the box otherwise.
      for (int i = 0; i < 4; i++) begin
         drive(1, 5, 5, 1'b1, 1'b0);
         push(1, K_RGB,  30'd0, "rst_rgb",  1);
         push(1, K_TICK, 30'd0, "rst_tick", 1);
         push(1, K_CNT,  30'd0, "rst_cnt",  1);
      end

      pix(1, 0,   0,   BOX,   "rel_origin_box");
      pix(1, 40,  0,   BG,    "rel_bg");
      pix(1, 31,  31,  BOX,   "rel_box_corner");
      pix(1, 32,  31,  BG,    "rel_box_edge_x");
      pix(1, 640, 0,   30'd0, "offscreen_x");
      pix(1, 0,   480, 30'd0, "offscreen_y");

      // Hold the last pixel 10 cycles: exactly one tick, the cycle after.
      drive(1, 639, 479, 1'b1, 1'b1);
      push(1, K_TICK, 30'd1, "ft_first", 1);
      push(1, K_RGB,  BG,    "ft_pix",   1);
      for (int i = 1; i < 10; i++) begin
         drive(1, 639, 479, 1'b1, 1'b1);
         push(1, K_TICK, 30'd0, "ft_hold", 1);
      end
      pix(1, 2, 2, BOX, "ft_moved_in");
      pix(1, 1, 1, BG,  "ft_moved_out");
      cntChk(1, 0, "ft_cnt");

      // Ticks 2..224: y reaches 448 = V_ACT-BOX_H and bounces; x is at 448.
      for (int i = 0; i < 223; i++) doTick(1, 1'b1);
      pix(1, 448, 448, BOX, "t224_box");
      pix(1, 448, 447, BG,  "t224_above");
      cntChk(1, 1, "t224_cnt");

      // Ticks 225..304: x hits 608 and bounces; y has come back down to 288.
      for (int i = 0; i < 80; i++) doTick(1, 1'b1);
      pix(1, 608, 288, BOX, "wall_box");
      pix(1, 607, 288, BG,  "wall_left");
      pix(1, 639, 319, BOX, "wall_far_corner");
      pix(1, 639, 320, BG,  "wall_below");
      cntChk(1, 2, "wall_cnt");

      doTick(1, 1'b1);
      pix(1, 606, 286, BOX, "after_wall_box");
      pix(1, 605, 286, BG,  "after_wall_left");

      // Freeze for five frames: ticks still pulse, nothing moves.
      for (int i = 0; i < 5; i++) doTick(1, 1'b0);
      pix(1, 606, 286, BOX, "frz_box");
      pix(1, 605, 286, BG,  "frz_left");
      cntChk(1, 2, "frz_cnt");

      doTick(1, 1'b1);
      pix(1, 604, 284, BOX, "reen_box");
      pix(1, 603, 284, BG,  "reen_left");
      pix(1, 604, 283, BG,  "reen_above");

      // 252 more ticks: x 604 -> 100; y bounces off 0 on the 142nd, ends at 220.
      for (int i = 0; i < 252; i++) doTick(1, 1'b1);
      pix(1, 100, 220, BOX, "x100_box");
      pix(1, 99,  220, BG,  "x100_left");
      pix(1, 100, 219, BG,  "x100_above");
      cntChk(1, 3, "x100_cnt");

      // Corner hit on the 64x64 instance.
      for (int i = 0; i < 15; i++) doTick(2, 1'b1);
      pix(2, 30, 30, BOX, "c15_box");
      pix(2, 29, 30, BG,  "c15_left");
      cntChk(2, 0, "c15_cnt");
      doTick(2, 1'b1);
      pix(2, 32, 32, BOX, "c16_box");
      pix(2, 31, 32, BG,  "c16_left");
      pix(2, 32, 31, BG,  "c16_above");
      cntChk(2, 1, "c16_cnt_once");
      doTick(2, 1'b1);
      pix(2, 30, 30, BOX, "c17_back_box");
      pix(2, 62, 30, BG,  "c17_right");
      cntChk(2, 1, "c17_cnt");

      // Reset coincident with a tick while dut1 sits at x=100.
      drive(1, 639, 479, 1'b1, 1'b0);
      push(1, K_TICK, 30'd0, "mr_tick", 1);
      push(1, K_RGB,  30'd0, "mr_rgb",  1);
      push(1, K_CNT,  30'd0, "mr_cnt",  1);
      drive(1, 0, 0, 1'b1, 1'b1);
      push(1, K_TICK, 30'd0, "mr_no_stale", 1);
      push(1, K_RGB,  BOX,   "mr_home",     1);
      pix(1, 31, 31, BOX, "mr_box_corner");
      pix(1, 32, 0,  BG,  "mr_box_edge");
      doTick(1, 1'b1);
      pix(1, 2, 2, BOX, "mr_dir_plus_in");
      pix(1, 1, 1, BG,  "mr_dir_plus_out");
      cntChk(1, 0, "mr_cnt_after");

      stimDone = 1'b1;
   end

   // -------------------------------------------------------------------------
   // Monitor / scoreboard
   // -------------------------------------------------------------------------
   initial begin
      exp_t        ent;
      logic [29:0] act;
      int          idle;
      idle = 0;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cycleCnt) begin
            ent = q.pop_front();
            act = '0;
            case (ent.kind)
               K_RGB:   act = (ent.dut == 1) ? {r1, g1, b1} : {r2, g2, b2};
               K_TICK:  act = (ent.dut == 1) ? 30'(tick1) : 30'(tick2);
               default: act = (ent.dut == 1) ? 30'(cnt1) : 30'(cnt2);
            endcase
            checks++;
            if (ent.cyc != cycleCnt || act !== ent.exp) begin
               failures++;
               $display("FAIL %s dut%0d cycle=%0d (due %0d) got=%h want=%h",
                        ent.name, ent.dut, cycleCnt, ent.cyc, act, ent.exp);
            end else begin
               $display("ok   %s dut%0d cycle=%0d value=%h", ent.name, ent.dut, cycleCnt, act);
            end
         end
         if (stimDone) begin
            if (q.size() == 0) break;
            idle++;
            if (idle > 20) begin
               $display("FAIL sb_timeout got=%0d pending want=0", q.size());
               failures += q.size();
               break;
            end
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
